// File: rtl/urv_trap_ctrl_if.sv
// Execute-stage bundle between the pipeline and the trap/counter unit.
// The pipeline side is the master; the trap unit answers with trap/mret.
interface urv_trap_ctrl_if;
    logic        x_stall_i;
    logic        x_kill_i;
    logic        x_valid_i;
    logic [31:0] x_pc_i;
    logic        d_is_csr_i;
    logic [11:0] d_csr_sel_i;
    logic [31:0] x_csr_write_value_i;
    logic        x_exception_i;
    logic [3:0]  x_exception_cause_i;
    logic        x_is_mret_i;
    logic        x_trap_o;
    logic        x_mret_o;

    modport master (
        output x_stall_i,
        output x_kill_i,
        output x_valid_i,
        output x_pc_i,
        output d_is_csr_i,
        output d_csr_sel_i,
        output x_csr_write_value_i,
        output x_exception_i,
        output x_exception_cause_i,
        output x_is_mret_i,
        input  x_trap_o,
        input  x_mret_o
    );

    modport slave (
        input  x_stall_i,
        input  x_kill_i,
        input  x_valid_i,
        input  x_pc_i,
        input  d_is_csr_i,
        input  d_csr_sel_i,
        input  x_csr_write_value_i,
        input  x_exception_i,
        input  x_exception_cause_i,
        input  x_is_mret_i,
        output x_trap_o,
        output x_mret_o
    );
endinterface

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap entry/return, interrupt CSRs and counters
// for the Kamikaze-uRV execute stage.
module urv_trap_ctrl #(
    parameter int g_irq_sync_stages = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    urv_trap_ctrl_if.slave x,
    input  logic        irq_i,
    input  logic        timer_irq_i,
    input  logic        timer_tick_i,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic [63:0] csr_cycles_o,
    output logic [63:0] csr_instrs_o,
    output logic [39:0] csr_time_o
);

    localparam int G = g_irq_sync_stages;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    logic          mie_q, mpie_q;
    logic          mtie_q, meie_q;
    logic          mtip_q;
    logic [G-1:0]  irq_sync_q;
    logic          meip;
    logic [31:0]   mepc_q;
    logic          mcause_irq_q;
    logic [3:0]    mcause_code_q;
    logic [63:0]   cycles_q, instrs_q;
    logic [39:0]   time_q;

    logic ce, pend, trap, mret, csr_we;
    logic wr_mstatus, wr_mie, wr_mepc, wr_mcause;
    logic [31:0] wval;

    always_comb begin
        meip       = irq_sync_q[G-1];
        ce         = x.x_valid_i & ~x.x_stall_i & ~x.x_kill_i;
        pend       = mie_q & ((meip & meie_q) | (mtip_q & mtie_q));
        trap       = ce & (x.x_exception_i | pend);
        mret       = ce & x.x_is_mret_i & ~trap;
        csr_we     = ce & x.d_is_csr_i & ~trap;
        wval       = x.x_csr_write_value_i;
        wr_mstatus = csr_we & (x.d_csr_sel_i == ADDR_MSTATUS);
        wr_mie     = csr_we & (x.d_csr_sel_i == ADDR_MIE);
        wr_mepc    = csr_we & (x.d_csr_sel_i == ADDR_MEPC);
        wr_mcause  = csr_we & (x.d_csr_sel_i == ADDR_MCAUSE);
    end

    assign x.x_trap_o = trap;
    assign x.x_mret_o = mret;

    // External irq is asynchronous; timer irq is already in our domain.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_sync_q <= '0;
            mtip_q     <= 1'b0;
        end else begin
            irq_sync_q <= {irq_sync_q[G-2:0], irq_i};
            mtip_q     <= timer_irq_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycles_q <= '0;
            instrs_q <= '0;
            time_q   <= '0;
        end else begin
            cycles_q <= cycles_q + 64'd1;
            if (ce && !trap)
                instrs_q <= instrs_q + 64'd1;
            if (timer_tick_i)
                time_q <= time_q + 40'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else begin
            unique case (1'b1)
                trap: begin
                    mpie_q <= mie_q;
                    mie_q  <= 1'b0;
                end
                mret: begin
                    mie_q  <= mpie_q;
                    mpie_q <= 1'b1;
                end
                wr_mstatus: begin
                    mie_q  <= wval[3];
                    mpie_q <= wval[7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtie_q <= 1'b0;
            meie_q <= 1'b0;
        end else if (wr_mie) begin
            mtie_q <= wval[7];
            meie_q <= wval[11];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mepc_q        <= '0;
            mcause_irq_q  <= 1'b0;
            mcause_code_q <= '0;
        end else begin
            unique case (1'b1)
                trap: begin
                    mepc_q       <= x.x_pc_i & 32'hFFFF_FFFC;
                    mcause_irq_q <= ~x.x_exception_i;
                    // Exception beats external irq, which beats timer.
                    if (x.x_exception_i)
                        mcause_code_q <= x.x_exception_cause_i;
                    else if (meip && meie_q)
                        mcause_code_q <= 4'hB;
                    else
                        mcause_code_q <= 4'h7;
                end
                wr_mepc:
                    mepc_q <= wval & 32'hFFFF_FFFC;
                wr_mcause: begin
                    mcause_irq_q  <= wval[31];
                    mcause_code_q <= wval[3:0];
                end
                default: ;
            endcase
        end
    end

    assign csr_mstatus_o = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
    assign csr_mie_o     = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
    assign csr_mip_o     = {20'b0, meip, 3'b0, mtip_q, 7'b0};
    assign csr_mepc_o    = mepc_q;
    assign csr_mcause_o  = {mcause_irq_q, 27'b0, mcause_code_q};
    assign csr_cycles_o  = cycles_q;
    assign csr_instrs_o  = instrs_q;
    assign csr_time_o    = time_q;

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Bench for urv_trap_ctrl: directed scenarios plus random traffic
// checked against a value-level model of the machine-mode CSRs.
module tb_urv_trap_ctrl;

    localparam int G = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        irq_i, timer_irq_i, timer_tick_i;
    logic [31:0] csr_mstatus_o, csr_mip_o, csr_mie_o;
    logic [31:0] csr_mepc_o, csr_mcause_o;
    logic [63:0] csr_cycles_o, csr_instrs_o;
    logic [39:0] csr_time_o;

    urv_trap_ctrl_if xif();

    urv_trap_ctrl #(.g_irq_sync_stages(G)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .x             (xif.slave),
        .irq_i         (irq_i),
        .timer_irq_i   (timer_irq_i),
        .timer_tick_i  (timer_tick_i),
        .csr_mstatus_o (csr_mstatus_o),
        .csr_mip_o     (csr_mip_o),
        .csr_mie_o     (csr_mie_o),
        .csr_mepc_o    (csr_mepc_o),
        .csr_mcause_o  (csr_mcause_o),
        .csr_cycles_o  (csr_cycles_o),
        .csr_instrs_o  (csr_instrs_o),
        .csr_time_o    (csr_time_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_mstatus, m_mie, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;
    logic [39:0] m_time;
    logic        m_tmr;
    bit          pipe[$];
    logic        obs_trap, obs_mret;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_mip();
        return (pipe[0] ? 32'h800 : 32'h0) | (m_tmr ? 32'h80 : 32'h0);
    endfunction

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0;
        m_cyc = 0; m_ins = 0; m_time = 0; m_tmr = 0;
        pipe.delete();
        repeat (G) pipe.push_back(1'b0);
    endtask

    task automatic check_csrs();
        chk("mstatus", csr_mstatus_o, m_mstatus);
        chk("mip", csr_mip_o, model_mip());
        chk("mie", csr_mie_o, m_mie);
        chk("mepc", csr_mepc_o, m_mepc);
        chk("mcause", csr_mcause_o, m_mcause);
        chk("cycles", csr_cycles_o, m_cyc);
        chk("instrs", csr_instrs_o, m_ins);
        chk("time", csr_time_o, m_time);
    endtask

    // Called at posedge+1 with inputs already driven; returns at posedge+1.
    task automatic cyc();
        logic [31:0] mip, val;
        logic ce, pend, trap, mret, csrw;
        #2;
        mip  = model_mip();
        ce   = xif.x_valid_i && !xif.x_stall_i && !xif.x_kill_i;
        pend = m_mstatus[3] && ((mip & m_mie) != 0);
        trap = ce && (xif.x_exception_i || pend);
        mret = ce && xif.x_is_mret_i && !trap;
        csrw = ce && xif.d_is_csr_i && !trap;
        obs_trap = xif.x_trap_o;
        obs_mret = xif.x_mret_o;
        chk("x_trap", obs_trap, trap);
        chk("x_mret", obs_mret, mret);
        @(posedge clk_i);
        val = xif.x_csr_write_value_i;
        m_cyc++;
        if (timer_tick_i) m_time++;
        if (ce && !trap) m_ins++;
        if (trap) begin
            m_mepc = xif.x_pc_i & ~32'h3;
            if (xif.x_exception_i)
                m_mcause = {28'b0, xif.x_exception_cause_i};
            else if ((mip & m_mie & 32'h800) != 0)
                m_mcause = 32'h8000_000B;
            else
                m_mcause = 32'h8000_0007;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else begin
            if (mret)
                m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            if (csrw) begin
                case (xif.d_csr_sel_i)
                    12'h300: if (!mret) m_mstatus = val & 32'h88;
                    12'h304: m_mie = val & 32'h880;
                    12'h341: m_mepc = val & ~32'h3;
                    12'h342: m_mcause = val & 32'h8000_000F;
                    default: ;
                endcase
            end
        end
        pipe.push_back(irq_i);
        void'(pipe.pop_front());
        m_tmr = timer_irq_i;
        #1;
        check_csrs();
    endtask

    task automatic drive(input logic v, input logic st, input logic csr,
                         input logic [11:0] sel, input logic [31:0] val,
                         input logic exc, input logic [3:0] cause,
                         input logic mr, input logic [31:0] pc);
        xif.x_valid_i           = v;
        xif.x_stall_i           = st;
        xif.x_kill_i            = 1'b0;
        xif.d_is_csr_i          = csr;
        xif.d_csr_sel_i         = sel;
        xif.x_csr_write_value_i = val;
        xif.x_exception_i       = exc;
        xif.x_exception_cause_i = cause;
        xif.x_is_mret_i         = mr;
        xif.x_pc_i              = pc;
    endtask

    task automatic instr(input logic csr, input logic [11:0] sel,
                         input logic [31:0] val, input logic exc,
                         input logic [3:0] cause, input logic mr,
                         input logic [31:0] pc);
        drive(1'b1, 1'b0, csr, sel, val, exc, cause, mr, pc);
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
            cyc();
        end
    endtask

    logic [11:0] sels[8];
    logic [63:0] ref_ins, ref_cyc;
    logic [39:0] ref_time;

    initial begin
        sels = '{12'h300, 12'h304, 12'h341, 12'h342,
                 12'h344, 12'hC00, 12'hB02, 12'h123};
        rst_i = 1'b0;
        irq_i = 1'b0; timer_irq_i = 1'b0; timer_tick_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_csrs();
        chk("rst_trap", xif.x_trap_o, 1'b0);
        chk("rst_mret", xif.x_mret_o, 1'b0);
        rst_i = 1'b1;

        idle(10);
        chk("cycles10", csr_cycles_o, 64'd10);
        chk("instrs0", csr_instrs_o, 64'd0);

        // Exception with a concurrent, discarded mie write.
        instr(1'b1, 12'h300, 32'h8, 1'b0, 4'h0, 1'b0, 32'h10);
        ref_ins = m_ins;
        instr(1'b1, 12'h304, 32'h880, 1'b1, 4'h2, 1'b0, 32'h100);
        chk("exc_trap", obs_trap, 1'b1);
        chk("exc_mepc", csr_mepc_o, 32'h100);
        chk("exc_mcause", csr_mcause_o, 32'h2);
        chk("exc_mstatus", csr_mstatus_o, 32'h80);
        chk("exc_mie", csr_mie_o, 32'h0);
        chk("exc_instrs", csr_instrs_o, ref_ins);

        // External interrupt through the synchronizer, then mret.
        instr(1'b1, 12'h304, 32'h800, 1'b0, 4'h0, 1'b0, 32'h20);
        instr(1'b1, 12'h300, 32'h8, 1'b0, 4'h0, 1'b0, 32'h24);
        irq_i = 1'b1;
        idle(1);
        instr(1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h1F0);
        chk("irq_early", obs_trap, 1'b0);
        instr(1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h200);
        chk("irq_trap", obs_trap, 1'b1);
        chk("irq_mcause", csr_mcause_o, 32'h8000_000B);
        chk("irq_mepc", csr_mepc_o, 32'h200);
        instr(1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 1'b1, 32'h204);
        chk("mret_out", obs_mret, 1'b1);
        chk("mret_trap", obs_trap, 1'b0);
        chk("mret_mstatus", csr_mstatus_o, 32'h88);
        instr(1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h208);
        chk("post_mret_trap", obs_trap, 1'b1);
        irq_i = 1'b0;
        idle(3);

        // Priority: exception over both pending interrupts.
        instr(1'b1, 12'h304, 32'h880, 1'b0, 4'h0, 1'b0, 32'h30);
        instr(1'b1, 12'h300, 32'h8, 1'b0, 4'h0, 1'b0, 32'h34);
        irq_i = 1'b1; timer_irq_i = 1'b1;
        idle(3);
        instr(1'b0, 12'h0, 32'h0, 1'b1, 4'h5, 1'b0, 32'h300);
        chk("prio_trap", obs_trap, 1'b1);
        chk("prio_mcause", csr_mcause_o, 32'h5);
        irq_i = 1'b0; timer_irq_i = 1'b0;
        idle(3);

        // Write masking.
        instr(1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b0, 32'h40);
        chk("mask_mstatus", csr_mstatus_o, 32'h88);
        instr(1'b1, 12'h304, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b0, 32'h44);
        chk("mask_mie", csr_mie_o, 32'h880);
        instr(1'b1, 12'h341, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b0, 32'h48);
        chk("mask_mepc", csr_mepc_o, 32'hFFFF_FFFC);
        instr(1'b1, 12'h344, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b0, 32'h4C);
        chk("mask_mip", csr_mip_o, 32'h0);

        // Time ticks, then a 5-cycle stall.
        ref_time = m_time;
        timer_tick_i = 1'b1;
        idle(37);
        timer_tick_i = 1'b0;
        chk("time_ticks", csr_time_o, ref_time + 40'd37);
        ref_ins = m_ins;
        ref_cyc = m_cyc;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 12'h300, 32'h0, 1'b1, 4'h3, 1'b0, 32'h50);
            cyc();
            chk("stall_trap", obs_trap, 1'b0);
        end
        chk("stall_instrs", csr_instrs_o, ref_ins);
        chk("stall_cycles", csr_cycles_o, ref_cyc + 64'd5);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic csr;
            csr = ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  csr, sels[$urandom_range(0, 7)], $urandom,
                  $urandom_range(0, 9) == 0, 4'($urandom),
                  !csr && ($urandom_range(0, 7) == 0), $urandom);
            xif.x_kill_i = ($urandom_range(0, 9) == 0);
            timer_tick_i = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) irq_i = ~irq_i;
            if ($urandom_range(0, 15) == 0) timer_irq_i = ~timer_irq_i;
            cyc();
        end

        // Asynchronous reset in the middle of a cycle.
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        check_csrs();
        chk("arst_trap", xif.x_trap_o, 1'b0);
        @(posedge clk_i);
        #1;
        check_csrs();
        rst_i = 1'b1;
        irq_i = 1'b0; timer_irq_i = 1'b0; timer_tick_i = 1'b0;
        idle(4);
        chk("arst_cycles", csr_cycles_o, 64'd4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
